// File: rtl/filtr_pkg.sv
// Shared definitions for the multi-channel notch filter: FSM encoding,
// coefficient select codes and datapath sizing helpers.
package filtr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] SEL_B0 = 3'd0;
  localparam logic [2:0] SEL_B1 = 3'd1;
  localparam logic [2:0] SEL_B2 = 3'd2;
  localparam logic [2:0] SEL_A1 = 3'd3;
  localparam logic [2:0] SEL_A2 = 3'd4;

  // Three guard bits cover the sum of five full-scale products.
  function automatic int acc_width(input int data_size, input int coef_size);
    return data_size + coef_size + 3;
  endfunction

  function automatic int rnd_bit(input int coef_size);
    return coef_size - 3;
  endfunction

  function automatic longint sat_max(input int data_size);
    return (longint'(1) << (data_size - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int data_size);
    return -(longint'(1) << (data_size - 1));
  endfunction

endpackage

// File: rtl/filtr_notch_mc_if.sv
// Sample/config bus of the notch filter. Optional bypass_mask exists only
// when FILTR_BYPASS_EN is defined. fsm_state is a debug view of the FSM.
interface filtr_notch_mc_if #(
  parameter int CHANNELS  = 2,
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 40
);
  import filtr_pkg::*;

  logic [CHANNELS*DATA_SIZE-1:0] data_in;
  logic [CHANNELS*DATA_SIZE-1:0] data_out;
  logic                          sample_trig;
  logic                          filter_done;
  logic                          busy;
  logic                          overrun;
  logic                          ovr_clr;
  logic                          cfg_we;
  logic [3:0]                    cfg_ch;
  logic [2:0]                    cfg_sel;
  logic [COEF_SIZE-1:0]          cfg_data;
  state_t                        fsm_state;
`ifdef FILTR_BYPASS_EN
  logic [CHANNELS-1:0]           bypass_mask;
`endif

  // sample_trig is a one-cycle strobe accepted only while busy=0;
  // filter_done pulses once when every channel of data_out is updated.
  modport master (
    output data_in, sample_trig, ovr_clr, cfg_we, cfg_ch, cfg_sel, cfg_data,
`ifdef FILTR_BYPASS_EN
    output bypass_mask,
`endif
    input  data_out, filter_done, busy, overrun, fsm_state
  );

  modport slave (
    input  data_in, sample_trig, ovr_clr, cfg_we, cfg_ch, cfg_sel, cfg_data,
`ifdef FILTR_BYPASS_EN
    input  bypass_mask,
`endif
    output data_out, filter_done, busy, overrun, fsm_state
  );

endinterface

// File: rtl/filtr_mac.sv
// Shared multiply-accumulate unit with round, arithmetic shift and
// saturation back to the sample width.
module filtr_mac
  import filtr_pkg::*;
#(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        sub,
  input  logic signed [COEF_SIZE-1:0] coef,
  input  logic signed [DATA_SIZE-1:0] data,
  output logic signed [DATA_SIZE-1:0] y
);
  localparam int ACC_W = acc_width(DATA_SIZE, COEF_SIZE);
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << rnd_bit(COEF_SIZE);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(sat_max(DATA_SIZE));
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(sat_min(DATA_SIZE));

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] scaled;

  always_comb begin
    prod   = ACC_W'(coef) * ACC_W'(data);
    addend = sub ? -prod : prod;
    scaled = (acc + RND) >>> (COEF_SIZE - 2);
    if (scaled > Y_MAX)      y = Y_MAX[DATA_SIZE-1:0];
    else if (scaled < Y_MIN) y = Y_MIN[DATA_SIZE-1:0];
    else                     y = scaled[DATA_SIZE-1:0];
  end

  // clr loads the first product of a channel instead of accumulating.
  always_ff @(posedge clk) begin
    if (reset)   acc <= '0;
    else if (en) acc <= (clr ? '0 : acc) + addend;
  end

endmodule

// File: rtl/filtr_notch_mc.sv
// Time-multiplexed Direct Form I notch biquad for CHANNELS streams.
// Optional feature macro: FILTR_BYPASS_EN (per-channel bypass mask).
module filtr_notch_mc
  import filtr_pkg::*;
#(
  parameter int DATA_SIZE = 24,
  parameter int COEF_SIZE = 40,
  parameter int CHANNELS  = 2,
  parameter logic signed [COEF_SIZE-1:0] B0_INIT = 40'sd274877906944,
  parameter logic signed [COEF_SIZE-1:0] B1_INIT = '0,
  parameter logic signed [COEF_SIZE-1:0] B2_INIT = 40'sd274877906944,
  parameter logic signed [COEF_SIZE-1:0] A1_INIT = '0,
  parameter logic signed [COEF_SIZE-1:0] A2_INIT = 40'sd269407836626
) (
  input logic        clk,
  input logic        reset,
  filtr_notch_mc_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  state_t state, state_nxt;
  logic [CH_W-1:0] ch;
  logic [2:0]      tap;
  logic            busy, trig_ok, ovr_set, cfg_ok, overrun_r, bypass_ch;

  logic signed [DATA_SIZE-1:0] x_lat [CHANNELS];
  logic signed [DATA_SIZE-1:0] x1 [CHANNELS];
  logic signed [DATA_SIZE-1:0] x2 [CHANNELS];
  logic signed [DATA_SIZE-1:0] y1 [CHANNELS];
  logic signed [DATA_SIZE-1:0] y2 [CHANNELS];
  logic signed [COEF_SIZE-1:0] coef [CHANNELS][5];
  logic [CHANNELS*DATA_SIZE-1:0] data_out_r;
  logic signed [COEF_SIZE-1:0] op_coef;
  logic signed [DATA_SIZE-1:0] op_data, y_mac;

`ifdef FILTR_BYPASS_EN
  logic [CHANNELS-1:0] bypass_lat;
  assign bypass_ch = bypass_lat[ch];
`else
  assign bypass_ch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    trig_ok   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        trig_ok   = bus.sample_trig;
        state_nxt = bus.sample_trig ? ST_MAC : ST_IDLE;
      end
      ST_MAC: begin
        busy = 1'b1;
        if (tap == 3'd4) state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        busy      = 1'b1;
        state_nxt = (ch == CH_LAST) ? ST_DONE : ST_MAC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ovr_set = busy && bus.sample_trig;
  assign cfg_ok  = bus.cfg_we && !busy && (32'(bus.cfg_ch) < CHANNELS) &&
                   (bus.cfg_sel <= SEL_A2);

  // Feedback taps are subtracted, so a1/a2 are stored with their natural sign.
  always_comb begin
    op_data = x_lat[ch];
    op_coef = coef[ch][SEL_B0];
    case (tap)
      3'd1: begin op_data = x1[ch]; op_coef = coef[ch][SEL_B1]; end
      3'd2: begin op_data = x2[ch]; op_coef = coef[ch][SEL_B2]; end
      3'd3: begin op_data = y1[ch]; op_coef = coef[ch][SEL_A1]; end
      3'd4: begin op_data = y2[ch]; op_coef = coef[ch][SEL_A2]; end
      default: ;
    endcase
  end

  filtr_mac #(.DATA_SIZE(DATA_SIZE), .COEF_SIZE(COEF_SIZE)) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_MAC),
    .clr   (tap == 3'd0),
    .sub   (tap >= 3'd3),
    .coef  (op_coef),
    .data  (op_data),
    .y     (y_mac)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ch         <= '0;
      tap        <= '0;
      overrun_r  <= 1'b0;
      data_out_r <= '0;
`ifdef FILTR_BYPASS_EN
      bypass_lat <= '0;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        x_lat[c]        <= '0;
        x1[c]           <= '0;
        x2[c]           <= '0;
        y1[c]           <= '0;
        y2[c]           <= '0;
        coef[c][SEL_B0] <= B0_INIT;
        coef[c][SEL_B1] <= B1_INIT;
        coef[c][SEL_B2] <= B2_INIT;
        coef[c][SEL_A1] <= A1_INIT;
        coef[c][SEL_A2] <= A2_INIT;
      end
    end else begin
      if (ovr_set)          overrun_r <= 1'b1;
      else if (bus.ovr_clr) overrun_r <= 1'b0;

      if (cfg_ok) coef[bus.cfg_ch[CH_W-1:0]][bus.cfg_sel] <= bus.cfg_data;

      if (trig_ok) begin
        ch  <= '0;
        tap <= '0;
`ifdef FILTR_BYPASS_EN
        bypass_lat <= bus.bypass_mask;
`endif
        for (int c = 0; c < CHANNELS; c++)
          x_lat[c] <= bus.data_in[c*DATA_SIZE +: DATA_SIZE];
      end else if (state == ST_MAC) begin
        tap <= tap + 3'd1;
      end else if (state == ST_ROUND) begin
        tap <= '0;
        ch  <= (ch == CH_LAST) ? '0 : ch + 1'b1;
        if (bypass_ch) begin
          data_out_r[ch*DATA_SIZE +: DATA_SIZE] <= x_lat[ch];
          x1[ch] <= '0;
          x2[ch] <= '0;
          y1[ch] <= '0;
          y2[ch] <= '0;
        end else begin
          data_out_r[ch*DATA_SIZE +: DATA_SIZE] <= y_mac;
          x1[ch] <= x_lat[ch];
          x2[ch] <= x1[ch];
          y1[ch] <= y_mac;
          y2[ch] <= y1[ch];
        end
      end
    end
  end

  assign bus.data_out    = data_out_r;
  assign bus.filter_done = (state == ST_DONE);
  assign bus.busy        = busy;
  assign bus.overrun     = overrun_r;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_filtr_notch_mc.sv
// Directed bench for filtr_notch_mc: a 2-channel and a 4-channel instance
// share clock and reset; each scenario task checks its own results.
module tb_filtr_notch_mc;
  import filtr_pkg::*;

  localparam logic signed [39:0] ONE   = 40'sd274877906944;
  localparam logic signed [39:0] ONE_5 = 40'sd412316860416;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filtr_notch_mc_if #(.CHANNELS(2), .DATA_SIZE(24), .COEF_SIZE(40)) if2 ();
  filtr_notch_mc_if #(.CHANNELS(4), .DATA_SIZE(24), .COEF_SIZE(40)) if4 ();

  filtr_notch_mc #(.DATA_SIZE(24), .COEF_SIZE(40), .CHANNELS(2)) u2 (
    .clk(clk), .reset(reset), .bus(if2));
  filtr_notch_mc #(.DATA_SIZE(24), .COEF_SIZE(40), .CHANNELS(4)) u4 (
    .clk(clk), .reset(reset), .bus(if4));

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic init_inputs();
    if2.data_in = '0; if2.sample_trig = 1'b0; if2.ovr_clr = 1'b0;
    if2.cfg_we = 1'b0; if2.cfg_ch = '0; if2.cfg_sel = '0; if2.cfg_data = '0;
    if4.data_in = '0; if4.sample_trig = 1'b0; if4.ovr_clr = 1'b0;
    if4.cfg_we = 1'b0; if4.cfg_ch = '0; if4.cfg_sel = '0; if4.cfg_data = '0;
`ifdef FILTR_BYPASS_EN
    if2.bypass_mask = '0;
    if4.bypass_mask = '0;
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg2(input logic [3:0] c, input logic [2:0] s, input logic [39:0] d);
    @(negedge clk);
    if2.cfg_we = 1'b1; if2.cfg_ch = c; if2.cfg_sel = s; if2.cfg_data = d;
    @(negedge clk);
    if2.cfg_we = 1'b0;
  endtask

  // k counts clock edges starting with the one that samples sample_trig.
  // mid_kind: 1 extra trig, 2 extra trig with ovr_clr, 3 cfg write ch1 b1=1.0
  task automatic run2(input logic signed [23:0] a, input logic signed [23:0] b,
                      input int mid_k, input int mid_kind,
                      output logic signed [23:0] y0, output logic signed [23:0] y1,
                      output int lat);
    @(negedge clk);
    if2.data_in = {b, a};
    if2.sample_trig = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if2.sample_trig = 1'b0; if2.ovr_clr = 1'b0; if2.cfg_we = 1'b0;
      if (k == mid_k) begin
        case (mid_kind)
          1: begin if2.data_in = {24'sd7000, 24'sd5000}; if2.sample_trig = 1'b1; end
          2: begin if2.sample_trig = 1'b1; if2.ovr_clr = 1'b1; end
          3: begin
            if2.cfg_we = 1'b1; if2.cfg_ch = 4'd1; if2.cfg_sel = SEL_B1; if2.cfg_data = ONE;
          end
          default: ;
        endcase
      end
      if (if2.filter_done === 1'b1) lat = k;
    end
    y0 = if2.data_out[23:0];
    y1 = if2.data_out[47:24];
  endtask

  task automatic test_reset();
    logic signed [23:0] y;
    int pulses;
    do_reset(3);
    checks++;
    if (if2.data_out !== 48'd0 || if4.data_out !== 96'd0) begin
      errors++; $display("FAIL reset_data_out got %h/%h want 0", if2.data_out, if4.data_out);
    end
    checks++;
    if (if2.filter_done !== 1'b0 || if2.busy !== 1'b0 || if2.overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags got done=%b busy=%b ovr=%b want 000",
                         if2.filter_done, if2.busy, if2.overrun);
    end
    checks++;
    if (if2.fsm_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d want %0d", if2.fsm_state, ST_IDLE);
    end
    // start a frame, provoke overrun, then reset before the frame finishes
    @(negedge clk);
    if2.data_in = {24'sd0, 24'sd1000}; if2.sample_trig = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if2.sample_trig = (k == 2);
    end
    y = if2.data_out[23:0];
    checks++;
    if (if2.busy !== 1'b1 || if2.overrun !== 1'b1 || y !== 24'sd1000) begin
      errors++; $display("FAIL pre_reset got busy=%b ovr=%b y0=%0d want 1 1 1000",
                         if2.busy, if2.overrun, y);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (if2.data_out !== 48'd0 || if2.busy !== 1'b0 || if2.overrun !== 1'b0 ||
        if2.filter_done !== 1'b0) begin
      errors++; $display("FAIL midframe_reset got out=%h busy=%b ovr=%b done=%b want 0",
                         if2.data_out, if2.busy, if2.overrun, if2.filter_done);
    end
    reset = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (if2.filter_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL aborted_frame_done got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_impulse();
    logic signed [23:0] xin [3] = '{24'sd1000, 24'sd0, 24'sd0};
    logic signed [23:0] exp0 [3] = '{24'sd1000, 24'sd0, 24'sd20};
    logic signed [23:0] y0, y1;
    int lat;
    do_reset(2);
    for (int f = 0; f < 3; f++) begin
      run2(xin[f], 24'sd0, 0, 0, y0, y1, lat);
      checks++;
      if (y0 !== exp0[f]) begin
        errors++; $display("FAIL impulse_y0 frame %0d got %0d want %0d", f, y0, exp0[f]);
      end
      checks++;
      if (y1 !== 24'sd0) begin
        errors++; $display("FAIL impulse_y1 frame %0d got %0d want 0", f, y1);
      end
      checks++;
      if (lat !== 13) begin
        errors++; $display("FAIL impulse_latency frame %0d got %0d want 13", f, lat);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [23:0] y0, y1;
    int lat;
    do_reset(2);
    cfg2(4'd0, SEL_B0, ONE_5);
    cfg2(4'd0, SEL_B2, 40'd0);
    run2(24'sd8388607, 24'sd0, 0, 0, y0, y1, lat);
    checks++;
    if (y0 !== 24'sd8388607) begin
      errors++; $display("FAIL sat_pos got %0d want 8388607", y0);
    end
    run2(-24'sd8388608, 24'sd0, 0, 0, y0, y1, lat);
    checks++;
    if (y0 !== -24'sd8388608) begin
      errors++; $display("FAIL sat_neg got %0d want -8388608", y0);
    end
  endtask

  task automatic test_independence();
    logic signed [23:0] y;
    int lat, busy_cnt;
    int expv [4] = '{100, 200, 300, 400};
    do_reset(2);
    @(negedge clk);
    if4.data_in = {24'sd400, 24'sd300, 24'sd200, 24'sd100};
    if4.sample_trig = 1'b1;
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if4.sample_trig = 1'b0;
      if (if4.busy === 1'b1) busy_cnt++;
      if (if4.filter_done === 1'b1) lat = k;
    end
    for (int c = 0; c < 4; c++) begin
      y = if4.data_out[c*24 +: 24];
      checks++;
      if (y !== 24'(expv[c])) begin
        errors++; $display("FAIL indep_ch%0d got %0d want %0d", c, y, expv[c]);
      end
    end
    checks++;
    if (lat !== 25) begin
      errors++; $display("FAIL indep_latency got %0d want 25", lat);
    end
    checks++;
    if (busy_cnt !== 24) begin
      errors++; $display("FAIL indep_busy_cycles got %0d want 24", busy_cnt);
    end
  endtask

  task automatic test_overrun();
    logic signed [23:0] y0, y1;
    int lat;
    do_reset(2);
    run2(24'sd1000, 24'sd0, 2, 1, y0, y1, lat);
    checks++;
    if (y0 !== 24'sd1000 || y1 !== 24'sd0 || lat !== 13) begin
      errors++; $display("FAIL overrun_frame got y0=%0d y1=%0d lat=%0d want 1000 0 13", y0, y1, lat);
    end
    checks++;
    if (if2.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set got %b want 1", if2.overrun);
    end
    @(negedge clk);
    if2.ovr_clr = 1'b1;
    @(negedge clk);
    if2.ovr_clr = 1'b0;
    checks++;
    if (if2.overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear got %b want 0", if2.overrun);
    end
    run2(24'sd0, 24'sd0, 3, 2, y0, y1, lat);
    checks++;
    if (if2.overrun !== 1'b1 || y0 !== 24'sd0) begin
      errors++; $display("FAIL overrun_set_wins got ovr=%b y0=%0d want 1 0", if2.overrun, y0);
    end
  endtask

  task automatic test_config();
    logic signed [23:0] y0, y1;
    int lat;
    do_reset(2);
    run2(24'sd0, 24'sd1000, 0, 0, y0, y1, lat);
    checks++;
    if (y1 !== 24'sd1000) begin
      errors++; $display("FAIL cfg_f1_ch1 got %0d want 1000", y1);
    end
    run2(24'sd0, 24'sd0, 2, 3, y0, y1, lat);
    checks++;
    if (y1 !== 24'sd0) begin
      errors++; $display("FAIL cfg_busy_dropped got %0d want 0", y1);
    end
    cfg2(4'd1, SEL_B1, ONE);
    cfg2(4'd1, 3'd6, 40'h7f_ffff_ffff);
    cfg2(4'd2, SEL_B0, 40'd0);
    run2(24'sd700, 24'sd400, 0, 0, y0, y1, lat);
    checks++;
    if (y1 !== 24'sd420) begin
      errors++; $display("FAIL cfg_f3_ch1 got %0d want 420", y1);
    end
    checks++;
    if (y0 !== 24'sd700) begin
      errors++; $display("FAIL cfg_bad_ch_ignored got %0d want 700", y0);
    end
    run2(24'sd0, 24'sd0, 0, 0, y0, y1, lat);
    checks++;
    if (y1 !== 24'sd400) begin
      errors++; $display("FAIL cfg_new_b1 got %0d want 400", y1);
    end
    checks++;
    if (y0 !== 24'sd0) begin
      errors++; $display("FAIL cfg_f4_ch0 got %0d want 0", y0);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_impulse();
    test_saturation();
    test_independence();
    test_overrun();
    test_config();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
